flash_rd_ctrl: RTL and testbench
================================

FLASH_RD_CTRL -- requirements
Module: flash_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_CNTL, default 2'd0, register address of SPI_CNTL.
REQ-002 SHALL have parameter ADDR_RDATA, default 2'd2, register address of SPI_READ_DATA.
REQ-003 SHALL have parameter ADDR_WDATA, default 2'd3, register address of SPI_WRITE_DATA.
REQ-004 SHALL have parameter CNTL_TX, default 8'h02, SPI_CNTL value enabling transmit only (SPTE=1, SPIE=0).
REQ-005 SHALL have parameter CNTL_RX, default 8'h01, SPI_CNTL value enabling receive only (SPIE=1, SPTE=0).
REQ-006 SHALL have parameter CS_GAP, default 8, number of idle cycles after spi_en deassert.
REQ-007 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-008 sys_rst  input  1  reset; synchronous and active-high.
REQ-009 start  input  1  one-cycle request pulse; ignored unless busy=0.
REQ-010 rd_addr  input  24  flash byte address; sampled when start is accepted.
REQ-011 rd_len  input  8  byte count; 0 means 256; sampled with rd_addr.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at end of transaction.
REQ-014 rd_data  output  8  received byte, valid with rd_valid.
REQ-015 rd_valid  output  1  one-cycle pulse per received byte; no backpressure.
REQ-016 spi_reg_addr  output  2  register address to SPI master.
REQ-017 spi_reg_data  inout  8  driven by this block only while spi_reg_cmd=2'b01, else high-Z.
REQ-018 spi_reg_cmd  output  2  2'b00 idle, 2'b01 write, 2'b10 read; never 2'b11.
REQ-019 spi_status  input  2  bit0 SPIF (rx byte ready), bit1 SPTEF (tx buffer empty).
REQ-020 spi_en  output  1  chip-select request to SPI master.

Function
REQ-021 SHALL issue each register access as exactly one cycle of spi_reg_cmd≠00, with spi_reg_cmd=00 in the following cycle.
REQ-022 States: IDLE, CFG_TX, SEND, DRAIN, CFG_RX, WAIT_RX, READ, STOP, GAP.
REQ-023 IDLE: start=1 -> latch rd_addr/rd_len, busy=1, go CFG_TX; byte index k=0.
REQ-024 CFG_TX: write CNTL_TX to ADDR_CNTL, assert spi_en (held high until STOP), go SEND.
REQ-025 SEND: when SPTEF=1 write byte k to ADDR_WDATA; bytes in order 8'h03, addr[23:16], addr[15:8], addr[7:0]; after k=3 go DRAIN, else k+1 and stay.
REQ-026 SEND SHALL NOT write while SPTEF=0; each write waits at least 1 cycle after the previous write before testing SPTEF.
REQ-027 DRAIN: wait SPTEF=1, then 4 further cycles, go CFG_RX.
REQ-028 CFG_RX: write CNTL_RX to ADDR_CNTL, load remaining count n=rd_len (0 -> 256, 9-bit), go WAIT_RX.
REQ-029 WAIT_RX: SPIF=1 -> go READ.
REQ-030 READ: drive spi_reg_cmd=10, spi_reg_addr=ADDR_RDATA, capture spi_reg_data same cycle into rd_data, rd_valid=1 next cycle; n-1; n reaches 0 -> STOP, else WAIT_RX.
REQ-031 STOP: deassert spi_en, write 8'h00 to ADDR_CNTL, go GAP.
REQ-032 GAP: count CS_GAP cycles, then pulse done, clear busy, return IDLE; start during GAP or any busy state ignored.
REQ-033 start coincident with done cycle SHALL be ignored (busy still 1 that cycle).
REQ-034 rd_addr near 24'hFFFFFF SHALL be sent unchanged; wrap is the flash's concern.
REQ-035 spi_reg_addr SHALL hold ADDR_CNTL when spi_reg_cmd=00.

Reset
REQ-036 sys_rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, rd_valid=0, rd_data=0, spi_en=0, spi_reg_cmd=00, spi_reg_addr=ADDR_CNTL, spi_reg_data high-Z, counters 0.
REQ-037 reset mid-transaction SHALL abort immediately (spi_en=0 next edge), no done pulse, no further register accesses.

Verification
REQ-038 start, rd_addr=24'h123456, rd_len=3, SPI-master model -> writes 03,12,34,56 in order, then exactly 3 rd_valid with model bytes, one done, spi_en low before done by ≥CS_GAP cycles.
REQ-039 rd_len=0 -> exactly 256 rd_valid pulses, then done.
REQ-040 SPTEF held 0 for 50 cycles after first write -> no further write until SPTEF=1.
REQ-041 start pulsed while busy and in done cycle -> ignored; latched address unchanged, single transaction.
REQ-042 sys_rst asserted during READ after 2 of 5 bytes -> spi_en=0, busy=0 next cycle, no done, no further rd_valid.
REQ-043 every cycle: spi_reg_cmd≠11, spi_reg_data high-Z unless cmd=01, no two consecutive non-00 cmd cycles.

Source files
------------

// File: rtl/flash_rd_ctrl.sv
// flash_rd_ctrl: issues an SPI-flash READ (0x03) through a register-mapped SPI master and streams the received bytes
// ports: sys_clk/sys_rst clock and sync reset; start/rd_addr/rd_len request; busy/done status;
//        rd_data/rd_valid byte stream; spi_reg_addr/spi_reg_data/spi_reg_cmd register bus;
//        spi_status {SPTEF,SPIF}; spi_en chip-select request
module flash_rd_ctrl #(
  parameter logic [1:0] ADDR_CNTL  = 2'd0,
  parameter logic [1:0] ADDR_RDATA = 2'd2,
  parameter logic [1:0] ADDR_WDATA = 2'd3,
  parameter logic [7:0] CNTL_TX    = 8'h02,
  parameter logic [7:0] CNTL_RX    = 8'h01,
  parameter int         CS_GAP     = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [23:0] rd_addr,
  input  logic [7:0]  rd_len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [1:0]  spi_reg_addr,
  inout  wire  [7:0]  spi_reg_data,
  output logic [1:0]  spi_reg_cmd,
  input  logic [1:0]  spi_status,
  output logic        spi_en
);
  typedef enum logic [3:0] {IDLE, CFG_TX, SEND, DRAIN, CFG_RX, WAIT_RX, READ, STOP, GAP} state_t;
  state_t state;
  logic [23:0] addr_q;
  logic [7:0] len_q, wdata, tx_byte;
  logic [1:0] k;
  logic [8:0] n;
  logic [15:0] cnt;
  logic sptef, spif;
  assign sptef = spi_status[1];
  assign spif = spi_status[0];
  assign spi_reg_data = spi_reg_cmd == 2'b01 ? wdata : 8'bz;
  always_comb tx_byte = k == 2'd0 ? 8'h03 : k == 2'd1 ? addr_q[23:16] : k == 2'd2 ? addr_q[15:8] : addr_q[7:0];
  // every access lasts one cycle: cmd/addr default back to idle each edge, and waits that
  // follow a write only test status once the bus has returned to idle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= 8'h00;
      spi_en <= 1'b0;
      spi_reg_cmd <= 2'b00;
      spi_reg_addr <= ADDR_CNTL;
      wdata <= 8'h00;
      addr_q <= 24'h0;
      len_q <= 8'h00;
      k <= 2'd0;
      n <= 9'd0;
      cnt <= 16'd0;
    end else begin
      spi_reg_cmd <= 2'b00;
      spi_reg_addr <= ADDR_CNTL;
      rd_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (busy) busy <= 1'b0;
          else if (start) begin
            addr_q <= rd_addr;
            len_q <= rd_len;
            k <= 2'd0;
            busy <= 1'b1;
            spi_en <= 1'b1;
            spi_reg_cmd <= 2'b01;
            wdata <= CNTL_TX;
            state <= CFG_TX;
          end
        end
        CFG_TX: state <= SEND;
        SEND: begin
          if (spi_reg_cmd == 2'b00 && sptef) begin
            spi_reg_cmd <= 2'b01;
            spi_reg_addr <= ADDR_WDATA;
            wdata <= tx_byte;
            k <= k + 2'd1;
            if (k == 2'd3) begin
              cnt <= 16'd0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt == 16'd0) begin
            if (spi_reg_cmd == 2'b00 && sptef) cnt <= 16'd1;
          end else if (cnt == 16'd4) begin
            cnt <= 16'd0;
            spi_reg_cmd <= 2'b01;
            wdata <= CNTL_RX;
            state <= CFG_RX;
          end else cnt <= cnt + 16'd1;
        end
        CFG_RX: begin
          n <= len_q == 8'h00 ? 9'd256 : {1'b0, len_q};
          state <= WAIT_RX;
        end
        WAIT_RX: begin
          if (spif) begin
            spi_reg_cmd <= 2'b10;
            spi_reg_addr <= ADDR_RDATA;
            state <= READ;
          end
        end
        READ: begin
          rd_data <= spi_reg_data;
          rd_valid <= 1'b1;
          n <= n - 9'd1;
          state <= n == 9'd1 ? STOP : WAIT_RX;
        end
        STOP: begin
          spi_en <= 1'b0;
          spi_reg_cmd <= 2'b01;
          wdata <= 8'h00;
          cnt <= 16'd0;
          state <= GAP;
        end
        GAP: begin
          if (int'(cnt) + 1 >= CS_GAP) begin
            cnt <= 16'd0;
            done <= 1'b1;
            state <= IDLE;
          end else cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_rd_ctrl.sv
// tb_flash_rd_ctrl: randomized bench with a behavioural SPI-master model and a transaction-level reference
module tb_flash_rd_ctrl;
  localparam logic [1:0] ADDR_CNTL = 2'd0, ADDR_RDATA = 2'd2, ADDR_WDATA = 2'd3;
  localparam logic [7:0] CNTL_TX = 8'h02, CNTL_RX = 8'h01;
  localparam int CS_GAP = 8, MAXC = 6000;
  logic clk = 1'b0, sys_rst = 1'b1, start = 1'b0;
  logic [23:0] rd_addr = 24'h0;
  logic [7:0] rd_len = 8'h0;
  logic busy, done, rd_valid, spi_en;
  logic [7:0] rd_data;
  logic [1:0] spi_reg_addr, spi_reg_cmd;
  wire [7:0] spi_reg_data;
  logic sptef = 1'b1, spif = 1'b0, rx_mode = 1'b0, stall_req = 1'b0, prev_en = 1'b0;
  logic [7:0] rx_byte = 8'h00, probe = 8'h00;
  logic [1:0] prev_cmd = 2'b00;
  int cyc = 0, proto_err = 0, tx_viol = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0;
  int tx_wait = 0, rx_wait = 0, tests = 0, fails = 0;
  logic [9:0] wlog[$], exp_w[$];
  logic [7:0] rlog[$], sent[$];
  int wcyc[$];
  always #5 clk = ~clk;
  // the master drives read data on a read, and a random probe when idle so a stray DUT drive corrupts it
  assign spi_reg_data = spi_reg_cmd == 2'b01 ? 8'bz : spi_reg_cmd == 2'b10 ? rx_byte : probe;
  flash_rd_ctrl #(.ADDR_CNTL(ADDR_CNTL), .ADDR_RDATA(ADDR_RDATA), .ADDR_WDATA(ADDR_WDATA),
                  .CNTL_TX(CNTL_TX), .CNTL_RX(CNTL_RX), .CS_GAP(CS_GAP)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .spi_reg_addr(spi_reg_addr), .spi_reg_data(spi_reg_data), .spi_reg_cmd(spi_reg_cmd),
    .spi_status({sptef, spif}), .spi_en(spi_en));
  // SPI-master model plus bus monitor, acting mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (sys_rst) begin
      sptef = 1'b1;
      spif = 1'b0;
      rx_mode = 1'b0;
      tx_wait = 0;
      rx_wait = 0;
      prev_cmd = 2'b00;
      prev_en = 1'b0;
    end else begin
      if (spi_reg_cmd == 2'b11) proto_err++;
      if (spi_reg_cmd != 2'b00 && prev_cmd != 2'b00) proto_err++;
      if (spi_reg_cmd == 2'b00 && (spi_reg_addr !== ADDR_CNTL || spi_reg_data !== probe)) proto_err++;
      if (spi_reg_cmd != 2'b00) acc_cnt++;
      if (spi_reg_cmd == 2'b01) begin
        wlog.push_back({spi_reg_addr, spi_reg_data});
        if (spi_reg_addr == ADDR_CNTL) rx_mode = spi_reg_data == CNTL_RX;
        if (spi_reg_addr == ADDR_WDATA) begin
          if (!sptef) tx_viol++;
          wcyc.push_back(cyc);
          sptef = 1'b0;
          tx_wait = stall_req ? 50 : $urandom_range(1, 4);
          stall_req = 1'b0;
        end
      end
      if (spi_reg_cmd == 2'b10) begin
        if (!spif || spi_reg_addr != ADDR_RDATA) proto_err++;
        sent.push_back(rx_byte);
        spif = 1'b0;
        rx_wait = $urandom_range(1, 6);
      end
      if (!sptef) begin
        if (tx_wait > 0) tx_wait--;
        else sptef = 1'b1;
      end
      if (rx_mode && spi_en && !spif) begin
        if (rx_wait > 0) rx_wait--;
        else begin
          spif = 1'b1;
          rx_byte = 8'($urandom);
        end
      end
      if (rd_valid) rlog.push_back(rd_data);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_en && !spi_en) fall_cyc = cyc;
      prev_cmd = spi_reg_cmd;
      prev_en = spi_en;
    end
    probe = 8'($urandom);
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  function automatic void set_exp(input logic [23:0] a);
    exp_w.delete();
    exp_w.push_back({ADDR_CNTL, CNTL_TX});
    exp_w.push_back({ADDR_WDATA, 8'h03});
    exp_w.push_back({ADDR_WDATA, a[23:16]});
    exp_w.push_back({ADDR_WDATA, a[15:8]});
    exp_w.push_back({ADDR_WDATA, a[7:0]});
    exp_w.push_back({ADDR_CNTL, CNTL_RX});
    exp_w.push_back({ADDR_CNTL, 8'h00});
  endfunction
  function automatic int wr_diff();
    int b = wlog.size() != exp_w.size() ? 1 : 0;
    for (int i = 0; i < wlog.size() && i < exp_w.size(); i++) if (wlog[i] !== exp_w[i]) b++;
    return b;
  endfunction
  function automatic int rd_diff();
    int b = rlog.size() != sent.size() ? 1 : 0;
    for (int i = 0; i < rlog.size() && i < sent.size(); i++) if (rlog[i] !== sent[i]) b++;
    return b;
  endfunction
  task automatic clr_logs();
    wlog.delete();
    rlog.delete();
    sent.delete();
    wcyc.delete();
    done_cnt = 0;
    tx_viol = 0;
    proto_err = 0;
  endtask
  task automatic run_txn(input logic [23:0] a, input logic [7:0] l);
    clr_logs();
    set_exp(a);
    start = 1'b1;
    rd_addr = a;
    rd_len = l;
    tick();
    start = 1'b0;
    for (int i = 0; i < MAXC && done_cnt == 0; i++) tick();
    tick();
    tick();
  endtask
  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    tests++; if (spi_en !== 1'b0) begin fails++; $display("FAIL reset_spi_en: got %b want 0", spi_en); end
    tests++; if (spi_reg_cmd !== 2'b00) begin fails++; $display("FAIL reset_cmd: got %b want 00", spi_reg_cmd); end
    tests++; if (spi_reg_addr !== ADDR_CNTL) begin fails++; $display("FAIL reset_addr: got %0d want %0d", spi_reg_addr, ADDR_CNTL); end
    sys_rst = 1'b0;
    repeat (3) tick();
    tests++; if (spi_reg_data !== probe) begin fails++; $display("FAIL reset_bus_z: got %h want %h", spi_reg_data, probe); end
    tests++; if (busy !== 1'b0 || proto_err != 0) begin fails++; $display("FAIL idle_after_reset: busy %b proto %0d want 0 0", busy, proto_err); end
  endtask
  task automatic test_basic();
    run_txn(24'h123456, 8'd3);
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    tests++; if (wr_diff() != 0) begin fails++; $display("FAIL basic_writes: %0d diffs over %0d writes want 0", wr_diff(), wlog.size()); end
    tests++; if (rlog.size() != 3) begin fails++; $display("FAIL basic_count: got %0d want 3", rlog.size()); end
    tests++; if (rd_diff() != 0) begin fails++; $display("FAIL basic_data: %0d diffs want 0", rd_diff()); end
    tests++; if (done_cyc - fall_cyc < CS_GAP) begin fails++; $display("FAIL basic_gap: got %0d want >=%0d", done_cyc - fall_cyc, CS_GAP); end
    tests++; if (busy !== 1'b0 || spi_en !== 1'b0) begin fails++; $display("FAIL basic_idle: busy %b spi_en %b want 0 0", busy, spi_en); end
    tests++; if (proto_err != 0 || tx_viol != 0) begin fails++; $display("FAIL basic_proto: got %0d/%0d want 0/0", proto_err, tx_viol); end
  endtask
  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      logic [23:0] a = t == 0 ? 24'hFFFFFF : 24'($urandom);
      logic [7:0] l = t == 1 ? 8'd1 : 8'($urandom_range(2, 24));
      run_txn(a, l);
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL rand_done[%0d]: got %0d want 1", t, done_cnt); end
      tests++; if (wr_diff() != 0) begin fails++; $display("FAIL rand_writes[%0d] addr %h: %0d diffs want 0", t, a, wr_diff()); end
      tests++; if (rlog.size() != int'(l)) begin fails++; $display("FAIL rand_count[%0d]: got %0d want %0d", t, rlog.size(), l); end
      tests++; if (rd_diff() != 0 || proto_err != 0 || tx_viol != 0) begin fails++; $display("FAIL rand_data[%0d]: diffs %0d proto %0d txv %0d want 0", t, rd_diff(), proto_err, tx_viol); end
    end
  endtask
  task automatic test_len256();
    run_txn(24'($urandom), 8'd0);
    tests++; if (rlog.size() != 256) begin fails++; $display("FAIL len256_count: got %0d want 256", rlog.size()); end
    tests++; if (rd_diff() != 0 || wr_diff() != 0) begin fails++; $display("FAIL len256_data: rd %0d wr %0d diffs want 0", rd_diff(), wr_diff()); end
    tests++; if (done_cnt != 1 || proto_err != 0) begin fails++; $display("FAIL len256_done: done %0d proto %0d want 1 0", done_cnt, proto_err); end
  endtask
  task automatic test_sptef_stall();
    int g;
    stall_req = 1'b1;
    run_txn(24'hC0FFEE, 8'd2);
    g = wcyc.size() >= 2 ? wcyc[1] - wcyc[0] : 0;
    tests++; if (g < 50) begin fails++; $display("FAIL stall_hold: write spacing %0d want >=50", g); end
    tests++; if (tx_viol != 0) begin fails++; $display("FAIL stall_viol: got %0d writes with SPTEF=0 want 0", tx_viol); end
    tests++; if (wr_diff() != 0 || done_cnt != 1 || rd_diff() != 0) begin fails++; $display("FAIL stall_txn: wr %0d rd %0d done %0d want 0 0 1", wr_diff(), rd_diff(), done_cnt); end
  endtask
  task automatic test_start_ignored();
    int i;
    clr_logs();
    set_exp(24'hA5C3E1);
    start = 1'b1; rd_addr = 24'hA5C3E1; rd_len = 8'd4;
    tick();
    start = 1'b0;
    repeat (6) tick();
    start = 1'b1; rd_addr = 24'h0F0F0F; rd_len = 8'd9;
    tick();
    start = 1'b0; rd_addr = 24'h0;
    for (i = 0; i < MAXC && done !== 1'b1; i++) tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ign_done_seen: got %b want 1", done); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy_in_done: got %b want 1", busy); end
    start = 1'b1; rd_addr = 24'h777777; rd_len = 8'd2;
    tick();
    start = 1'b0;
    repeat (40) tick();
    tests++; if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL ign_single: done %0d busy %b want 1 0", done_cnt, busy); end
    tests++; if (wr_diff() != 0) begin fails++; $display("FAIL ign_writes: %0d diffs want 0", wr_diff()); end
    tests++; if (rlog.size() != 4 || rd_diff() != 0) begin fails++; $display("FAIL ign_data: count %0d diffs %0d want 4 0", rlog.size(), rd_diff()); end
  endtask
  task automatic test_abort();
    int acc;
    clr_logs();
    start = 1'b1; rd_addr = 24'h5A5A5A; rd_len = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < MAXC && rlog.size() < 2; i++) tick();
    tests++; if (rlog.size() != 2) begin fails++; $display("FAIL abort_wait: got %0d bytes want 2", rlog.size()); end
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (spi_en !== 1'b0 || busy !== 1'b0 || spi_reg_cmd !== 2'b00) begin fails++; $display("FAIL abort_now: spi_en %b busy %b cmd %b want 0 0 00", spi_en, busy, spi_reg_cmd); end
    tick();
    tick();
    sys_rst = 1'b0;
    acc = acc_cnt;
    repeat (300) tick();
    tests++; if (acc_cnt != acc) begin fails++; $display("FAIL abort_access: got %0d accesses want 0", acc_cnt - acc); end
    tests++; if (rlog.size() != 2 || done_cnt != 0 || busy !== 1'b0) begin fails++; $display("FAIL abort_quiet: bytes %0d done %0d busy %b want 2 0 0", rlog.size(), done_cnt, busy); end
    run_txn(24'h00ABCD, 8'd3);
    tests++; if (done_cnt != 1 || wr_diff() != 0 || rd_diff() != 0 || rlog.size() != 3) begin fails++; $display("FAIL abort_recover: done %0d wr %0d rd %0d n %0d want 1 0 0 3", done_cnt, wr_diff(), rd_diff(), rlog.size()); end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_random();
    test_len256();
    test_sptef_stall();
    test_start_ignored();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
